// File: rtl/avs_fifo_sink_pkg.sv
// rtl/avs_fifo_sink_pkg.sv - register map, status/control bit positions and watchdog limit
package avs_fifo_sink_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_THRESH = 2'd3;

  localparam logic S1_ADDR_DATA  = 1'b0;
  localparam logic S1_ADDR_LEVEL = 1'b1;

  localparam int STATUS_EMPTY_BIT = 0;
  localparam int STATUS_FULL_BIT  = 1;
  localparam int STATUS_OVF_BIT   = 2;
  localparam int STATUS_UNF_BIT   = 3;
  localparam int STATUS_LEVEL_LSB = 8;

  localparam int CTRL_FLUSH_BIT = 0;
  localparam int CTRL_CLEAR_BIT = 1;

  typedef logic [7:0] wdog_t;
  localparam wdog_t WDOG_LIMIT = 8'd255;

endpackage

// File: rtl/avs_fifo_sink_sync_fifo_core.sv
// rtl/avs_fifo_sink_sync_fifo_core.sv - circular buffer with pointers, level and flush
module sync_fifo_core #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  input  logic              flush,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] head,
  output logic [LW-1:0]     level
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;

  // Storage is not reset; it is unreachable until written again.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);
  assign head  = mem[rd_ptr];

endmodule

// File: rtl/avs_fifo_sink.sv
// rtl/avs_fifo_sink.sv - Avalon-MM FIFO sink; AVS_FIFO_SINK_WATERMARK_EN adds THRESH register and irq
module avs_fifo_sink
  import avs_fifo_sink_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int LVL_W  = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        avs_s0_address,
  input  logic              avs_s0_read,
  input  logic              avs_s0_write,
  output logic              avs_s0_waitrequest,
  output logic [DATA_W-1:0] avs_s0_readdata,
  input  logic [DATA_W-1:0] avs_s0_writedata,
  input  logic              avs_s1_address,
  input  logic              avs_s1_read,
  output logic              avs_s1_waitrequest,
  output logic [DATA_W-1:0] avs_s1_readdata
`ifdef AVS_FIFO_SINK_WATERMARK_EN
  ,
  output logic              irq
`endif
);

  logic              full;
  logic              empty;
  logic [DATA_W-1:0] head;
  logic [LVL_W-1:0]  level;
  logic              s0_data_wr;
  logic              s0_ctrl_wr;
  logic              s1_data_rd;
  logic              push;
  logic              pop;
  logic              flush;
  wdog_t             s0_wdog;
  wdog_t             s1_wdog;
  logic              overflow;
  logic              underflow;
  logic [DATA_W-1:0] status;
  logic              unused_wdata;

  assign unused_wdata = ^avs_s0_writedata;

  assign s0_data_wr = avs_s0_write && (avs_s0_address == ADDR_DATA);
  assign s0_ctrl_wr = avs_s0_write && (avs_s0_address == ADDR_CTRL);
  assign s1_data_rd = avs_s1_read && (avs_s1_address == S1_ADDR_DATA);

  // Stalls look only at the registered level, so a same-cycle pop never frees a full stall.
  assign avs_s0_waitrequest = s0_data_wr && full;
  assign avs_s1_waitrequest = s1_data_rd && empty;

  assign push  = s0_data_wr && !full;
  assign pop   = s1_data_rd && !empty;
  assign flush = s0_ctrl_wr && avs_s0_writedata[CTRL_FLUSH_BIT];

  sync_fifo_core #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_core (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (avs_s0_writedata),
    .pop       (pop),
    .flush     (flush),
    .full      (full),
    .empty     (empty),
    .head      (head),
    .level     (level)
  );

  // Stall watchdogs saturate at the limit; a stall on the limit cycle raises the sticky bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s0_wdog   <= '0;
      s1_wdog   <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      s0_wdog <= avs_s0_waitrequest ? ((s0_wdog == WDOG_LIMIT) ? s0_wdog : s0_wdog + 1'b1) : '0;
      s1_wdog <= avs_s1_waitrequest ? ((s1_wdog == WDOG_LIMIT) ? s1_wdog : s1_wdog + 1'b1) : '0;
      if (s0_ctrl_wr && avs_s0_writedata[CTRL_CLEAR_BIT]) begin
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end
      if (avs_s0_waitrequest && (s0_wdog == WDOG_LIMIT)) overflow  <= 1'b1;
      if (avs_s1_waitrequest && (s1_wdog == WDOG_LIMIT)) underflow <= 1'b1;
    end
  end

  always_comb begin
    status                                = '0;
    status[STATUS_EMPTY_BIT]              = empty;
    status[STATUS_FULL_BIT]               = full;
    status[STATUS_OVF_BIT]                = overflow;
    status[STATUS_UNF_BIT]                = underflow;
    status[STATUS_LEVEL_LSB +: LVL_W]     = level;
  end

`ifdef AVS_FIFO_SINK_WATERMARK_EN
  logic [LVL_W-1:0] thresh;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      thresh <= LVL_W'(DEPTH / 2);
      irq    <= 1'b0;
    end else begin
      if (avs_s0_write && (avs_s0_address == ADDR_THRESH)) thresh <= avs_s0_writedata[LVL_W-1:0];
      irq <= (level >= thresh) && (thresh != '0);
    end
  end
`endif

  always_comb begin
    avs_s0_readdata = '0;
    if (avs_s0_read) begin
      case (avs_s0_address)
        ADDR_STATUS: avs_s0_readdata = status;
`ifdef AVS_FIFO_SINK_WATERMARK_EN
        ADDR_THRESH: avs_s0_readdata = DATA_W'(thresh);
`endif
        default:     avs_s0_readdata = '0;
      endcase
    end
  end

  always_comb begin
    avs_s1_readdata = '0;
    if (pop) begin
      avs_s1_readdata = head;
    end else if (avs_s1_read && (avs_s1_address == S1_ADDR_LEVEL)) begin
      avs_s1_readdata = DATA_W'(level);
    end
  end

endmodule

// File: doc/avs_fifo_sink.md
Name: avs_fifo_sink

Overview:
- Avalon-MM slave FIFO that sits directly downstream of the DMA's destination master (m1). The DMA writes words into s0; a consumer drains them through s1.
- Backpressure is via waitrequest: s0 stalls when full, s1 stalls when empty.
- s0 also carries status and flush control so DMA software can check fill level.

Parameters:
- DATA_W, 32, data width of both ports.
- DEPTH, 16, number of FIFO entries; must be a power of two, minimum 2.
- LVL_W, 5, width of the level counter; must equal log2(DEPTH)+1.

Ports:
- clk  in  1  single clock.
- reset_n  in  1  reset, asynchronous assert, active-low.
- avs_s0_address  in  2  0=DATA (write pushes), 1=STATUS (read), 2=CTRL (write), 3=THRESH (feature only).
- avs_s0_read  in  1  read strobe.
- avs_s0_write  in  1  write strobe.
- avs_s0_waitrequest  out  1  stall for s0.
- avs_s0_readdata  out  DATA_W  STATUS/THRESH read data.
- avs_s0_writedata  in  DATA_W  push data or control value.
- avs_s1_address  in  1  0=DATA (read pops), 1=LEVEL (read, no pop).
- avs_s1_read  in  1  read strobe.
- avs_s1_waitrequest  out  1  stall for s1.
- avs_s1_readdata  out  DATA_W  popped word or level.
- irq  out  1  watermark interrupt; present only with the feature.

Behaviour:
- Reset (reset_n=0, async): wr_ptr=0, rd_ptr=0, level=0, both waitrequests=0, both readdata=0, overflow/underflow sticky bits=0, irq=0, thresh=DEPTH/2.
- Both ports have read latency 0: readdata is valid in the cycle where read=1 and waitrequest=0. readdata is 0 in any cycle with no accepted read.
- s0 write to DATA:
  - level<DEPTH: waitrequest=0; the word is stored at wr_ptr at the clock edge; wr_ptr+1 (mod DEPTH); level+1.
  - level==DEPTH: waitrequest=1; nothing stored; the master holds its signals.
- Full/empty decisions use registered level only. There is no same-cycle bypass: a pop in the same cycle does not release a full-stall on s0.
- s0 read STATUS, never stalls: bit0=empty, bit1=full, bit2=overflow sticky, bit3=underflow sticky, bits[8+LVL_W-1:8]=level, all other bits 0.
- s0 write CTRL, never stalls:
  - bit0=1 flushes: ptrs=0, level=0.
  - bit1=1 clears the sticky bits.
  - Other bits are ignored.
- s0 writes to STATUS and s0 reads of DATA/CTRL: waitrequest=0, no effect, readdata=0.
- s1 read DATA:
  - level>0: waitrequest=0; readdata=mem[rd_ptr]; rd_ptr+1; level-1.
  - level==0: waitrequest=1.
- s1 read LEVEL: never stalls; readdata = zero-extended level.
- Simultaneous accepted push and pop: level unchanged; both pointers advance; the popped word is the old head. When level==1, the pushed word does not bypass.
- Flush in the same cycle as an accepted pop: the pop returns the current head, then the flush result wins, so level=0 next cycle.
- Sticky bits:
  - overflow sets when s0 DATA write is held by waitrequest for 256 consecutive cycles (stall watchdog).
  - underflow sets when s1 DATA read is held for 256 consecutive cycles.
  - Each watchdog counter is 8 bits, saturates, and clears when the stall ends.
- Reset asserted mid-transfer: all state clears immediately. Any partially handshaked access is dropped. FIFO contents are undefined but unreachable.

Optional Feature:
- Macro: AVS_FIFO_SINK_WATERMARK_EN.
- Defined:
  - s0 address 3 is THRESH. Writes load writedata[LVL_W-1:0]; reads return it.
  - irq is registered: irq <= (level >= thresh) && (thresh != 0).
  - Updates one cycle after level changes.
- Undefined:
  - No irq port and no thresh register.
  - Address 3 behaves as an unmapped address: no stall, read returns 0.

Decomposition:
- Package avs_fifo_sink_pkg holds:
  - address constants ADDR_DATA=0, ADDR_STATUS=1, ADDR_CTRL=2, ADDR_THRESH=3, S1_ADDR_DATA=0, S1_ADDR_LEVEL=1;
  - STATUS bit positions;
  - CTRL bit positions;
  - WDOG_LIMIT=255.
- Sub-module sync_fifo_core (parameters DATA_W, DEPTH) holds the memory, pointers, level and flush. It exposes push/pop/full/empty/head/level.
- The top level handles address decode, waitrequest, watchdogs, sticky bits and irq.

Test Plan:
- Push 0xA0..0xAF (16 words) via s0 → 16 writes with waitrequest=0; STATUS full=1, level=16. A 17th write 0xB0 stalls until one s1 pop, then is accepted.
- Pop 16 words via s1 → data 0xA0..0xAF in order. A 17th read sees waitrequest=1; s1 LEVEL reads 0.
- level=1 (head 0x11), same cycle: push 0x22 and pop → pop returns 0x11, level stays 1, next pop returns 0x22.
- level=5, write CTRL=0x1 concurrently with an s1 pop → pop returns the head, level=0 next cycle, STATUS empty=1.
- Hold an s1 DATA read on an empty FIFO for 256 cycles → STATUS bit3=1. Write CTRL=0x2 → bit3=0.
- With AVS_FIFO_SINK_WATERMARK_EN, thresh=4: push 4 words → irq=1 the cycle after level reaches 4; one pop → irq=0 the next cycle.
